duty_ramp_seq: RTL and testbench

DUTY_RAMP_SEQ -- requirements
Module: duty_ramp_seq

---
 rtl/duty_ramp_seq.sv | 155 +++++++++++++++
 tb/tb_duty_ramp_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/duty_ramp_seq.sv
// Duty-cycle ramp sequencer: ramps duty_cycle 0 -> MAX_DUTY, holds, and optionally
// ramps back down once (mode 1) or continuously as a triangle (mode 2).
module duty_ramp_seq #(
   parameter int unsigned DW       = 4,
   parameter int unsigned MAX_DUTY = 10,
   parameter int unsigned STEP_W   = 7,
   parameter int unsigned HOLD_W   = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step_load,
   input  logic [HOLD_W-1:0] hold_load,
   output logic [DW-1:0]     duty_cycle,
   output logic              ready,
   output logic              busy,
   output logic              wrap
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UP   = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DOWN = 2'd3;

   localparam logic [DW-1:0] DMAX = DW'(MAX_DUTY);

   logic [1:0]        state, state_n;
   logic              start_r;
   logic [1:0]        mode_r, mode_n;
   logic [STEP_W-1:0] step_r, step_n;
   logic [HOLD_W-1:0] hold_r, hold_n;
   logic [STEP_W-1:0] step_cnt, step_cnt_n;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
   logic [DW-1:0]     duty_n;
   logic              ready_n, wrap_n, busy_n;

   logic              start_edge_c;
   logic [STEP_W-1:0] step_eff_c;
   logic [HOLD_W-1:0] hold_eff_c;
   logic              bounce_c;

   assign start_edge_c = start & ~start_r;
   assign step_eff_c   = (step_load == '0) ? STEP_W'(1) : step_load;
   assign hold_eff_c   = (hold_load == '0) ? HOLD_W'(1) : hold_load;
   // modes 1 and 2 come back down after the hold; modes 0 and 3 finish there
   assign bounce_c     = (mode_r == 2'd1) || (mode_r == 2'd2);

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         start_r    <= 1'b0;
         mode_r     <= '0;
         step_r     <= '0;
         hold_r     <= '0;
         step_cnt   <= '0;
         hold_cnt   <= '0;
         duty_cycle <= '0;
         ready      <= 1'b0;
         wrap       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         start_r    <= start;
         mode_r     <= mode_n;
         step_r     <= step_n;
         hold_r     <= hold_n;
         step_cnt   <= step_cnt_n;
         hold_cnt   <= hold_cnt_n;
         duty_cycle <= duty_n;
         ready      <= ready_n;
         wrap       <= wrap_n;
         busy       <= busy_n;
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_n    = state;
      mode_n     = mode_r;
      step_n     = step_r;
      hold_n     = hold_r;
      step_cnt_n = step_cnt;
      hold_cnt_n = hold_cnt;
      duty_n     = duty_cycle;
      ready_n    = 1'b0;
      wrap_n     = 1'b0;

      if (state == S_IDLE) begin
         if (start_edge_c && !stop) begin
            mode_n     = mode;
            step_n     = step_eff_c;
            hold_n     = hold_eff_c;
            step_cnt_n = step_eff_c - STEP_W'(1);
            duty_n     = '0;
            state_n    = S_UP;
         end
      end else if (stop) begin
         duty_n  = '0;
         state_n = S_IDLE;
      end else begin
         case (state)
            S_UP: begin
               if (step_cnt == '0) begin
                  step_cnt_n = step_r - STEP_W'(1);
                  duty_n     = duty_cycle + DW'(1);
                  if (duty_cycle + DW'(1) == DMAX) begin
                     hold_cnt_n = hold_r - HOLD_W'(1);
                     state_n    = S_HOLD;
                  end
               end else begin
                  step_cnt_n = step_cnt - STEP_W'(1);
               end
            end
            S_HOLD: begin
               if (hold_cnt == '0) begin
                  if (bounce_c) begin
                     step_cnt_n = step_r - STEP_W'(1);
                     state_n    = S_DOWN;
                  end else begin
                     duty_n  = '0;
                     ready_n = 1'b1;
                     state_n = S_IDLE;
                  end
               end else begin
                  hold_cnt_n = hold_cnt - HOLD_W'(1);
               end
            end
            S_DOWN: begin
               if (step_cnt == '0) begin
                  step_cnt_n = step_r - STEP_W'(1);
                  duty_n     = duty_cycle - DW'(1);
                  if (duty_cycle == DW'(1)) begin
                     if (mode_r == 2'd2) begin
                        wrap_n  = 1'b1;
                        state_n = S_UP;
                     end else begin
                        ready_n = 1'b1;
                        state_n = S_IDLE;
                     end
                  end
               end else begin
                  step_cnt_n = step_cnt - STEP_W'(1);
               end
            end
            default: state_n = S_IDLE;
         endcase
      end

      busy_n = (state_n != S_IDLE);
   end

endmodule

// File: tb/tb_duty_ramp_seq.sv
// Bench for duty_ramp_seq: directed and randomized sequences checked against
// a closed-form model of the duty waveform as a function of cycles since start.
module tb_duty_ramp_seq;

   localparam int M = 10;

   logic       clk = 1'b0;
   logic       rst, start, stop;
   logic [1:0] mode;
   logic [6:0] step_load;
   logic [13:0] hold_load;
   logic [3:0] duty_cycle;
   logic       ready, busy, wrap;

   int vectors = 0;
   int errs    = 0;

   duty_ramp_seq #(.DW(4), .MAX_DUTY(M), .STEP_W(7), .HOLD_W(14)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .step_load(step_load), .hold_load(hold_load),
      .duty_cycle(duty_cycle), .ready(ready), .busy(busy), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      vectors++;
      assert (obs === 32'(expv)) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // duty within one up/hold/down period, tt cycles after the period start
   function automatic int phase(input int s, input int h, input int tt);
      int u;
      u = M * s;
      if (tt < u)     return tt / s;
      if (tt < u + h) return M;
      return M - (tt - u - h) / s;
   endfunction

   // cycles from start edge to completion edge (modes 0/1); period for mode 2
   function automatic int span(input int md, input int s, input int h);
      if (md == 1 || md == 2) return 2 * M * s + h;
      return M * s + h;
   endfunction

   function automatic void expect_at(input int md, input int s, input int h, input int t,
                                     output int d, output int r, output int w, output int b);
      int e;
      e = span(md, s, h);
      r = 0; w = 0; b = 1;
      if (md == 2) begin
         d = phase(s, h, t % e);
         w = (t > 0 && t % e == 0) ? 1 : 0;
      end else if (t < e) begin
         d = phase(s, h, t);
      end else begin
         d = 0; b = 0;
         r = (t == e) ? 1 : 0;
      end
   endfunction

   task automatic check_all(input string tag, input int d, input int r, input int w, input int b);
      chk({tag, ".duty"},  32'(duty_cycle), d);
      chk({tag, ".ready"}, 32'(ready), r);
      chk({tag, ".wrap"},  32'(wrap), w);
      chk({tag, ".busy"},  32'(busy), b);
   endtask

   task automatic launch(input int md, input int sl, input int hl);
      start = 1'b0; stop = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; mode = 2'(md); step_load = 7'(sl); hold_load = 14'(hl);
      @(posedge clk); #1;
      check_all("launch", 0, 0, 0, 1);
   endtask

   // cycles 1..len after a start edge; sa>0 aborts with stop at cycle sa
   task automatic follow(input string tag, input int md, input int sl, input int hl,
                         input int len, input int sa, input bit rnd);
      int s, h, lim, d, r, w, b;
      s = eff(sl); h = eff(hl);
      lim = (sa > 0) ? sa : ((md == 2) ? len : span(md, s, h));
      for (int t = 1; t <= len; t++) begin
         if (t <= lim) begin
            stop  = (t == sa);
            start = rnd ? 1'($urandom) : 1'b0;
         end else begin
            start = 1'b0;
            stop  = rnd ? 1'($urandom) : 1'b0;
         end
         if (rnd) begin
            mode = 2'($urandom); step_load = 7'($urandom); hold_load = 14'($urandom);
         end
         @(posedge clk); #1;
         if (sa > 0 && t >= sa) begin
            d = 0; r = 0; w = 0; b = 0;
         end else begin
            expect_at(md, s, h, t, d, r, w, b);
         end
         check_all(tag, d, r, w, b);
      end
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      int md, sl, hl, len, sa, e;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      mode = '0; step_load = '0; hold_load = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0);
      rst = 1'b0;

      launch(0, 3, 5);  follow("mode0", 0, 3, 5, 40, 0, 1'b0);
      launch(1, 3, 5);  follow("mode1", 1, 3, 5, 70, 0, 1'b1);
      launch(2, 3, 5);  follow("mode2", 2, 3, 5, 140, 135, 1'b1);
      launch(0, 3, 5);  follow("abort", 0, 3, 5, 26, 20, 1'b0);
      launch(3, 2, 1);  follow("mode3", 3, 2, 1, 25, 0, 1'b0);
      launch(0, 0, 5);  follow("step0", 0, 0, 5, 20, 0, 1'b1);
      launch(1, 1, 0);  follow("hold0", 1, 1, 0, 24, 0, 1'b0);
      launch(0, 2, 3);  follow("stop_at_end", 0, 2, 3, 26, 23, 1'b0);

      // stop coincident with a start edge in IDLE: start ignored
      start = 1'b0; @(posedge clk); #1;
      start = 1'b1; stop = 1'b1; @(posedge clk); #1;
      chk("stop_vs_start.busy", 32'(busy), 0);
      stop = 1'b0; @(posedge clk); #1;
      chk("held_start.busy", 32'(busy), 0);

      // reset mid-sequence, then start held high through reset release
      launch(1, 3, 5);  follow("pre_rst", 1, 3, 5, 14, 0, 1'b0);
      rst = 1'b1; start = 1'b1; @(posedge clk); #1;
      check_all("mid_rst", 0, 0, 0, 0);
      @(posedge clk); #1;
      mode = 2'd0; step_load = 7'd2; hold_load = 14'd1; rst = 1'b0;
      @(posedge clk); #1;
      check_all("rst_release_start", 0, 0, 0, 1);
      follow("post_rst", 0, 2, 1, 24, 0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         md = int'($urandom_range(0, 3));
         sl = int'($urandom_range(0, 4));
         hl = int'($urandom_range(0, 6));
         e  = span(md, eff(sl), eff(hl));
         sa = 0;
         if (md == 2) begin
            len = e + int'($urandom_range(0, e));
            sa  = int'($urandom_range(1, len));
         end else begin
            len = e + 3;
            if ($urandom_range(0, 2) == 0) sa = int'($urandom_range(1, e));
         end
         launch(md, sl, hl);
         follow("rand", md, sl, hl, len, sa, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
